// File: rtl/conv_window_fetch_ctrl.sv
// conv_window_fetch_ctrl
//   Read-side controller for the 4096 x 8-bit image RAM. On start it walks
//   every valid 3x3 window of an IMG_W x IMG_H row-major image. For each
//   window it issues nine reads, gathers the pixels into a 72-bit word and
//   offers that word to the convolution datapath over valid/ready.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   start                begin a full-image scan (honoured only when idle)
//   busy, done           busy outside IDLE; done pulses once per finished scan
//   ram_r_en             RAM read enable (only high while issuing)
//   ram_address          RAM read address (held when not reading)
//   ram_data_out         RAM read data, valid the cycle after ram_r_en
//   win_valid/win_ready  window handshake
//   win_data             pixel k = dy*3+dx in bits [8k+7:8k]
//   win_row, win_col     top-left corner of the window on offer
module conv_window_fetch_ctrl #(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int ROW_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             ram_r_en,
    output logic [11:0]      ram_address,
    input  logic [7:0]       ram_data_out,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [71:0]      win_data,
    output logic [ROW_W-1:0] win_row,
    output logic [ROW_W-1:0] win_col
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_DRAIN   = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    localparam logic [11:0]      IMG_W12 = 12'(IMG_W);
    localparam logic [ROW_W-1:0] LAST_C  = ROW_W'(IMG_W - 3);
    localparam logic [ROW_W-1:0] LAST_R  = ROW_W'(IMG_H - 3);

    logic [2:0]       state_reg, state_next;
    logic [3:0]       k_reg, k_next;
    logic [ROW_W-1:0] r_reg, r_next;
    logic [ROW_W-1:0] c_reg, c_next;
    logic [11:0]      addr_hold_reg;

    logic [1:0]  dy, dx;
    logic [11:0] issue_addr;
    logic        transfer;
    logic        cap_en;
    logic [3:0]  cap_slot;

    // k -> (dy, dx) without a divider
    always_comb begin
        dy = 2'd0;
        dx = 2'd0;
        case (k_reg)
            4'd0: begin dy = 2'd0; dx = 2'd0; end
            4'd1: begin dy = 2'd0; dx = 2'd1; end
            4'd2: begin dy = 2'd0; dx = 2'd2; end
            4'd3: begin dy = 2'd1; dx = 2'd0; end
            4'd4: begin dy = 2'd1; dx = 2'd1; end
            4'd5: begin dy = 2'd1; dx = 2'd2; end
            4'd6: begin dy = 2'd2; dx = 2'd0; end
            4'd7: begin dy = 2'd2; dx = 2'd1; end
            4'd8: begin dy = 2'd2; dx = 2'd2; end
            default: begin dy = 2'd0; dx = 2'd0; end
        endcase
    end

    assign issue_addr = (12'(r_reg) + 12'(dy)) * IMG_W12 + 12'(c_reg) + 12'(dx);
    assign transfer   = (state_reg == S_PRESENT) && win_ready;

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        r_next     = r_reg;
        c_next     = c_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_ISSUE;
                    k_next     = 4'd0;
                    r_next     = '0;
                    c_next     = '0;
                end
            end
            S_ISSUE: begin
                if (k_reg == 4'd8) begin
                    state_next = S_DRAIN;
                    k_next     = 4'd0;
                end else begin
                    k_next = k_reg + 4'd1;
                end
            end
            S_DRAIN: begin
                state_next = S_PRESENT;
            end
            S_PRESENT: begin
                if (transfer) begin
                    k_next = 4'd0;
                    if ((r_reg == LAST_R) && (c_reg == LAST_C)) begin
                        // Park the position at the origin once the scan ends
                        state_next = S_DONE;
                        r_next     = '0;
                        c_next     = '0;
                    end else begin
                        state_next = S_ISSUE;
                        if (c_reg < LAST_C) begin
                            c_next = c_reg + 1'b1;
                        end else begin
                            c_next = '0;
                            r_next = r_reg + 1'b1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            k_reg         <= 4'd0;
            r_reg         <= '0;
            c_reg         <= '0;
            addr_hold_reg <= 12'd0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            r_reg     <= r_next;
            c_reg     <= c_next;
            if (state_reg == S_ISSUE) begin
                addr_hold_reg <= issue_addr;
            end
        end
    end

    // Read data lands one cycle after its request, so the slot written is
    // always one behind the slot currently being requested; DRAIN picks up 8.
    assign cap_en   = ((state_reg == S_ISSUE) && (k_reg != 4'd0)) || (state_reg == S_DRAIN);
    assign cap_slot = (state_reg == S_DRAIN) ? 4'd8 : (k_reg - 4'd1);

    generate
        for (genvar gi = 0; gi < 9; gi++) begin : g_lane
            logic [7:0] lane_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_reg <= 8'd0;
                end else if (cap_en && (cap_slot == 4'(gi))) begin
                    lane_reg <= ram_data_out;
                end
            end
            assign win_data[8*gi +: 8] = lane_reg;
        end
    endgenerate

    assign busy        = (state_reg != S_IDLE);
    assign done        = (state_reg == S_DONE);
    assign ram_r_en    = (state_reg == S_ISSUE);
    // Address follows the live request while issuing, otherwise the last one
    assign ram_address = (state_reg == S_ISSUE) ? issue_addr : addr_hold_reg;
    assign win_valid   = (state_reg == S_PRESENT);
    assign win_row     = r_reg;
    assign win_col     = c_reg;

endmodule

// File: tb/tb_conv_window_fetch_ctrl.sv
// Testbench for conv_window_fetch_ctrl on a 5x4 image with RAM[i] = i.
// Stimulus pushes hand-tabulated expected reads and windows into queues;
// negedge monitors pop and compare whenever the DUT reads or transfers.
module tb_conv_window_fetch_ctrl;

    localparam int IMG_W = 5;
    localparam int IMG_H = 4;
    localparam int ROW_W = 3;
    localparam int NWIN  = 6;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             busy;
    logic             done;
    logic             ram_r_en;
    logic [11:0]      ram_address;
    logic [7:0]       ram_data_out = 8'h00;
    logic             win_valid;
    logic             win_ready = 1'b0;
    logic [71:0]      win_data;
    logic [ROW_W-1:0] win_row;
    logic [ROW_W-1:0] win_col;

    conv_window_fetch_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .ROW_W(ROW_W)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
        .ram_r_en(ram_r_en), .ram_address(ram_address), .ram_data_out(ram_data_out),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .win_row(win_row), .win_col(win_col)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Image RAM model with registered read
    logic [7:0] mem [0:4095];
    initial for (int i = 0; i < 4096; i++) mem[i] = 8'(i);
    always @(posedge clk) if (ram_r_en) ram_data_out <= mem[ram_address];

    typedef struct {
        logic [71:0]      data;
        logic [ROW_W-1:0] row;
        logic [ROW_W-1:0] col;
    } win_t;

    win_t        exp_win[$];
    logic [11:0] exp_addr[$];

    int checks = 0;
    int errors = 0;
    int transfers = 0;
    int done_pulses = 0;

    // Hand-computed 5x4 tables: window base address r*5+c, and 3x3 offsets
    int base_tab [NWIN] = '{0, 1, 2, 5, 6, 7};
    int row_tab  [NWIN] = '{0, 0, 0, 1, 1, 1};
    int col_tab  [NWIN] = '{0, 1, 2, 0, 1, 2};
    int off_tab  [9]    = '{0, 1, 2, 5, 6, 7, 10, 11, 12};
    logic [71:0] first_win = 72'h0C0B0A070605020100;

    task automatic chk(input string name, input logic [71:0] got, input logic [71:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic push_scan();
        win_t w;
        for (int wi = 0; wi < NWIN; wi++) begin
            w.data = '0;
            for (int k = 0; k < 9; k++) begin
                exp_addr.push_back(12'(base_tab[wi] + off_tab[k]));
                w.data[8*k +: 8] = 8'(base_tab[wi] + off_tab[k]);
            end
            w.row = ROW_W'(row_tab[wi]);
            w.col = ROW_W'(col_tab[wi]);
            exp_win.push_back(w);
        end
    endtask

    // Read monitor
    always @(negedge clk) begin
        logic [11:0] a;
        if (ram_r_en) begin
            if (exp_addr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read: got addr %0d required no read (cycle %0d)", ram_address, cyc);
            end else begin
                a = exp_addr.pop_front();
                chk("ram_address", 72'(ram_address), 72'(a));
                $display("read addr=%0d expected=%0d", ram_address, a);
            end
        end
    end

    // Window monitor
    always @(negedge clk) begin
        win_t w;
        if (win_valid && win_ready) begin
            transfers++;
            if (exp_win.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_window: got row %0d col %0d required none", win_row, win_col);
            end else begin
                w = exp_win.pop_front();
                chk("win_data", win_data, w.data);
                chk("win_row", 72'(win_row), 72'(w.row));
                chk("win_col", 72'(win_col), 72'(w.col));
                $display("window row=%0d col=%0d data=%018h", win_row, win_col, win_data);
            end
        end
        if (done) done_pulses++;
    end

    // One full scan. bp: cycles of backpressure in the first PRESENT.
    // spam: pulse start repeatedly while busy. The start edge is the clock
    // edge on which start is driven high; done is expected 67+bp cycles later.
    task automatic scan(input int bp, input bit spam, input string tag);
        int start_cyc;
        int t0;
        int d0;
        int g;
        push_scan();
        t0 = transfers;
        d0 = done_pulses;
        win_ready = (bp == 0);
        @(posedge clk); #1;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
        if (bp > 0) begin
            g = 0;
            while (!win_valid && g < 100) begin @(posedge clk); #1; g++; end
            chk({tag, "_present_timeout"}, 72'(g < 100), 72'(1));
            for (int i = 0; i < bp; i++) begin
                chk({tag, "_bp_valid"}, 72'(win_valid), 72'(1));
                chk({tag, "_bp_data"}, win_data, first_win);
                chk({tag, "_bp_no_read"}, 72'(ram_r_en), 72'(0));
                @(posedge clk); #1;
            end
            win_ready = 1'b1;
        end
        g = 0;
        while (!done && g < 400) begin
            @(posedge clk); #1;
            g++;
            start = spam && ((cyc - start_cyc) % 12 == 5) && ((cyc - start_cyc) < 60);
        end
        start = 1'b0;
        chk({tag, "_done_timeout"}, 72'(g < 400), 72'(1));
        chk({tag, "_done_cycle"}, 72'(cyc - start_cyc), 72'(67 + bp));
        $display("%s done after %0d cycles", tag, cyc - start_cyc);
        @(posedge clk); #1;
        chk({tag, "_busy_after"}, 72'(busy), 72'(0));
        chk({tag, "_done_width"}, 72'(done), 72'(0));
        repeat (10) @(posedge clk);
        #1;
        chk({tag, "_transfers"}, 72'(transfers - t0), 72'(NWIN));
        chk({tag, "_done_pulses"}, 72'(done_pulses - d0), 72'(1));
        chk({tag, "_win_left"}, 72'(exp_win.size()), 72'(0));
        chk({tag, "_addr_left"}, 72'(exp_addr.size()), 72'(0));
    endtask

    initial begin
        int g;
        int t0;
        // Reset for two edges
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 72'(busy), 72'(0));
        chk("rst_done", 72'(done), 72'(0));
        chk("rst_r_en", 72'(ram_r_en), 72'(0));
        chk("rst_addr", 72'(ram_address), 72'(0));
        chk("rst_valid", 72'(win_valid), 72'(0));
        chk("rst_data", win_data, 72'(0));
        chk("rst_row", 72'(win_row), 72'(0));
        chk("rst_col", 72'(win_col), 72'(0));
        repeat (5) @(negedge clk);
        chk("idle_busy", 72'(busy), 72'(0));

        scan(0, 1'b0, "scan");
        scan(5, 1'b0, "bp");

        // Reset during third ISSUE cycle of the second window
        push_scan();
        win_ready = 1'b1;
        t0 = transfers;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        g = 0;
        while (transfers == t0 && g < 200) begin @(posedge clk); #1; g++; end
        chk("mid_first_transfer_timeout", 72'(g < 200), 72'(1));
        chk("mid_issue0_addr", 72'(ram_address), 72'(1));
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("mid_issue2_r_en", 72'(ram_r_en), 72'(1));
        chk("mid_issue2_addr", 72'(ram_address), 72'(3));
        @(posedge clk); #1;
        rst = 1'b0;
        exp_addr.delete();
        exp_win.delete();
        chk("mid_busy", 72'(busy), 72'(0));
        chk("mid_r_en", 72'(ram_r_en), 72'(0));
        chk("mid_valid", 72'(win_valid), 72'(0));
        chk("mid_row", 72'(win_row), 72'(0));
        chk("mid_col", 72'(win_col), 72'(0));
        repeat (3) @(posedge clk);

        // Rescan from origin with start spammed while busy
        scan(0, 1'b1, "spam");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion required finish by 100000");
        $fatal(1, "watchdog");
    end

endmodule
